// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundles the I-cache, D-cache and main-memory signals that meet
//             at mem_arbiter.
//  Modports : slave  - the arbiter's view. It takes cache requests and drives
//                      the memory port.
//             master - the environment's view (caches and memory model).
//  Signals  : i_req/i_addr -> i_rdata/i_rvalid/i_done      (I-cache)
//             d_req/d_we/d_addr/d_wdata/d_wstrb
//                          -> d_rdata/d_rvalid/d_done      (D-cache)
//             mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb
//                          <- mem_rdata/mem_ack            (memory)
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // I-cache side
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_rvalid;
  logic              i_done;
  // D-cache side
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_wstrb;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;
  logic              d_done;
  // Memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_rvalid, i_done,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_rdata, d_rvalid, d_done,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack
  );

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_rvalid, i_done,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_rdata, d_rvalid, d_done,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one main-memory port between the I-cache refill path
//             (read-only line refills) and the D-cache path (line refills or
//             single-word write-through stores).
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous, active-high reset
//             bus  - mem_arbiter_if.slave (cache request/response and memory
//                    handshake signals)
//  Options  : ARB_RR_EN - when defined, simultaneous requests alternate owner
//             (a last_owner register, reset to I). When undefined, D always
//             wins over I.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input wire           clk,
  input wire           rst,
  mem_arbiter_if.slave bus
);

  localparam int c_BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int c_OFF_W  = $clog2(LINE_WORDS) + 2;

  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0]   c_LINE_MASK =
      ~((ADDR_W'(1) << c_OFF_W) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0]   c_WORD_MASK = ~ADDR_W'(3);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_GNT_I = 2'd1;
  localparam logic [1:0] c_GNT_D = 2'd2;
  localparam logic [1:0] c_TURN  = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                r_owner_d;
  logic                r_we;
  logic [ADDR_W-1:0]   r_base;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_wstrb;
  logic [c_BEAT_W-1:0] r_beat;

  logic                w_busy;
  logic                w_grant;
  logic                w_grant_d;
  logic                w_beat_ack;
  logic                w_last_beat;
  logic                w_grant_we;
  logic [ADDR_W-1:0]   w_req_addr;

  // --------------------------------------------------------------------------
  // Arbitration. Requests are only looked at in IDLE.
  // --------------------------------------------------------------------------
  assign w_busy  = (r_state == c_GNT_I) || (r_state == c_GNT_D);
  assign w_grant = (r_state == c_IDLE) && (bus.i_req || bus.d_req);

`ifdef ARB_RR_EN
  logic r_last_d;

  // On a tie, the side that did not own the previous transaction wins.
  assign w_grant_d = bus.d_req && (!bus.i_req || !r_last_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (w_grant) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  assign w_grant_d = bus.d_req;
`endif

  assign w_grant_we = w_grant_d && bus.d_we;
  assign w_req_addr = w_grant_d ? bus.d_addr : bus.i_addr;

  // An ack counts only while a request is actually presented.
  assign w_beat_ack  = w_busy && bus.mem_ack;
  assign w_last_beat = r_we || (r_beat == c_LAST_BEAT);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_grant) begin
          w_state_nxt = w_grant_d ? c_GNT_D : c_GNT_I;
        end
      end
      c_GNT_I, c_GNT_D: begin
        if (w_beat_ack && w_last_beat) begin
          w_state_nxt = c_TURN;
        end
      end
      c_TURN:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction registers. These are captured at the grant edge, so later
  // changes on the request inputs have no effect on the running transaction.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_base    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_beat    <= '0;
    end else if (w_grant) begin
      r_owner_d <= w_grant_d;
      r_we      <= w_grant_we;
      r_base    <= w_req_addr & (w_grant_we ? c_WORD_MASK : c_LINE_MASK);
      r_wdata   <= bus.d_wdata;
      r_wstrb   <= bus.d_wstrb;
      r_beat    <= '0;
    end else if (w_beat_ack) begin
      r_beat    <= r_beat + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. All outputs are gated to zero outside their valid window.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.mem_req   = w_busy;
    bus.mem_we    = w_busy && r_we;
    bus.mem_addr  = w_busy ? (r_base + (ADDR_W'(r_beat) << 2)) : '0;
    bus.mem_wdata = (w_busy && r_we) ? r_wdata : '0;
    bus.mem_wstrb = (w_busy && r_we) ? r_wstrb : '0;

    bus.i_rvalid  = w_beat_ack && !r_we && (r_state == c_GNT_I);
    bus.d_rvalid  = w_beat_ack && !r_we && (r_state == c_GNT_D);
    bus.i_rdata   = bus.i_rvalid ? bus.mem_rdata : '0;
    bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;

    // TURN is exactly the cycle after the last ack, so done lives there.
    bus.i_done    = (r_state == c_TURN) && !r_owner_d;
    bus.d_done    = (r_state == c_TURN) &&  r_owner_d;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path and the data-cache path of the pipelined RV32I core.
- I-side issues read-only line refills. D-side issues line refills or single-word write-through stores.
- Sits between both caches and the memory model. The data cache's data_ready, which feeds the pipeline's waiting logic, is derived from this block's d_done.

Parameters:
- LINE_WORDS, 4, words per cache line refill; power of 2, >=1.
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data word width; fixed 32 for RV32I.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  I-cache refill request; held until i_done.
- i_addr  in  ADDR_W  I-side miss byte address.
- i_rdata  out  DATA_W  refill word to I-cache.
- i_rvalid  out  1  i_rdata valid this cycle.
- i_done  out  1  one-cycle pulse, I transaction complete.
- d_req  in  1  D-cache request; held until d_done.
- d_we  in  1  1 = single-word write, 0 = line refill.
- d_addr  in  ADDR_W  D-side byte address.
- d_wdata  in  DATA_W  store data.
- d_wstrb  in  4  byte enables for the write.
- d_rdata  out  DATA_W  refill word to D-cache.
- d_rvalid  out  1  d_rdata valid this cycle.
- d_done  out  1  one-cycle pulse, D transaction complete.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  word-aligned memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wstrb  out  4  memory byte enables.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  beat accepted / read data valid.

Behaviour:
- Reset (async, rst=1): state=IDLE, beat=0, owner=none.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, i_*/d_* outputs.
  - Reset mid-transaction aborts it with no done pulse. Requesters must re-request.
- States:
  - IDLE: no grant.
  - GNT_I: I-side owns the port.
  - GNT_D: D-side owns the port.
  - TURN: one-cycle gap after any completion.
- IDLE arbitration at the clock edge: d_req=1 -> GNT_D; else i_req=1 -> GNT_I; else stay in IDLE. Fixed priority D > I.
- On grant, register the request fields:
  - Base address: line-aligned (low log2(LINE_WORDS)+2 bits cleared) for refills; word-aligned for writes.
  - we, wdata, wstrb.
  - beat = 0.
- Memory handshake in GNT_x:
  - mem_req=1 starting the cycle after the grant edge. Latency from req to first mem_req is 1 cycle.
  - mem_addr = base + 4*beat.
  - Refill: mem_we=0, mem_wstrb=0.
  - Write: mem_we=1, mem_wdata/mem_wstrb from the registered copies.
  - mem_req, mem_addr, mem_we, mem_wdata and mem_wstrb stay stable until mem_ack.
- Refill beats:
  - Each cycle with mem_ack=1, the owner's rdata = mem_rdata and rvalid=1 combinationally, and beat increments.
  - The ack with beat==LINE_WORDS-1 is the last beat.
- Write: a single beat; the first mem_ack is the last beat. rvalid stays 0.
- Completion:
  - The cycle after the last ack: owner's done=1 for exactly one cycle, mem_req=0, state=TURN.
  - TURN -> IDLE next cycle, and arbitration resumes.
  - Minimum time between consecutive grants is 3 cycles.
- Request inputs are ignored while not in IDLE. Dropping req mid-transaction does not cancel it; it completes and pulses done.
- The non-owner's rvalid and done stay 0 throughout.
- Beat counter width is log2(LINE_WORDS), minimum 1. It resets to 0 on each grant.
- mem_ack while mem_req=0 is ignored.

Optional Feature:
- Macro ARB_RR_EN.
- Defined:
  - A 1-bit last_owner register, reset to I.
  - When both requests are present in IDLE, grant the side that did not own the previous transaction.
  - When only one side requests, grant it as usual.
- Undefined: fixed D > I priority. The I-side can starve under continuous d_req.

Test Plan:
- I refill alone:
  - Stimulus: i_req=1, i_addr=0x0000_1234, mem_ack one cycle after each mem_req beat.
  - Required: mem_addr 0x1230, 0x1234, 0x1238, 0x123C.
  - Required: 4 i_rvalid pulses carrying mem_rdata; i_done 1 cycle after the last ack; d_* outputs stay 0.
- D write:
  - Stimulus: d_req=1, d_we=1, d_addr=0x0000_0106, d_wdata=0xDEAD_BEEF, d_wstrb=4'b1100, ack delayed 3 cycles.
  - Required: mem_addr=0x104 and mem_we=1 held stable all 3 wait cycles.
  - Required: single d_done pulse; d_rvalid never asserts.
- Simultaneous i_req and d_req at the same edge:
  - Without ARB_RR_EN: D granted first, I granted after TURN.
  - With ARB_RR_EN and last_owner=D: I granted first.
- Back-to-back D requests with i_req held (no ARB_RR_EN):
  - Required: I never granted while d_req is re-asserted in IDLE.
  - Required: the gap between d_done and the next mem_req is exactly 2 cycles.
- Reset mid-refill:
  - Stimulus: rst=1 asynchronously after the 2nd ack of an I refill.
  - Required: mem_req=0 immediately; no i_done pulse.
  - Required: after reset release, a fresh i_req restarts at beat 0.
- Req drop and stray ack:
  - Stimulus: drop i_req after the 1st beat; pulse mem_ack in IDLE.
  - Required: the refill still completes all 4 beats with an i_done pulse.
  - Required: the stray ack changes no output.
